// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal store strobes and the wait-counter width helper.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] STRB_B0 = 4'b0001;
  localparam logic [3:0] STRB_B1 = 4'b0010;
  localparam logic [3:0] STRB_B2 = 4'b0100;
  localparam logic [3:0] STRB_B3 = 4'b1000;
  localparam logic [3:0] STRB_H0 = 4'b0011;
  localparam logic [3:0] STRB_H1 = 4'b1100;
  localparam logic [3:0] STRB_W  = 4'b1111;

  // Only naturally aligned byte, halfword and word stores are accepted.
  function automatic logic strobe_legal(input logic [3:0] strb);
    logic ok;
    case (strb)
      STRB_B0, STRB_B1, STRB_B2, STRB_B3, STRB_H0, STRB_H1, STRB_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Counter must hold WAIT_CYCLES itself; never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Word-wide backing store split into four byte lanes so each lane maps onto
// its own RAM with a plain write enable; read data is registered on re.
module mem_word_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          lane_mem[index] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          lane_rdata_reg <= lane_mem[index];
        end
      end

      assign rdata[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Target end of the core's data load/store port: one request at a time,
// WAIT_CYCLES wait states, then a held response until the initiator takes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] index_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  error_reg;
  logic                  load_ok_reg;
  logic                  resp_error_reg;

  logic                  accept;
  logic                  req_error;
  logic                  entering_resp;
  logic                  from_live;
  logic                  c_write;
  logic                  c_error;
  logic [ADDR_WIDTH-1:0] c_index;
  logic [31:0]           c_wdata;
  logic [3:0]            c_wstrb;
  logic                  array_we;
  logic                  array_re;
  logic [31:0]           array_rdata;

  assign accept    = req_valid && req_ready;
  assign req_error = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
                     (req_write && !strobe_legal(req_wstrb));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= CNT_ONE) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    resp_valid = (state_reg == ST_RESP);
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      cnt_next = CNT_LOAD;
    end else if (state_reg == ST_WAIT) begin
      cnt_next = cnt_reg - CNT_ONE;
    end
  end

  // With zero wait states the commit edge is the accept edge itself, so the
  // commit uses the live request instead of the not-yet-captured copy.
  always_comb begin
    from_live = (state_reg == ST_IDLE);
    c_write   = from_live ? req_write                   : write_reg;
    c_error   = from_live ? req_error                   : error_reg;
    c_index   = from_live ? req_addr[ADDR_WIDTH+1:2]    : index_reg;
    c_wdata   = from_live ? req_wdata                   : wdata_reg;
    c_wstrb   = from_live ? req_wstrb                   : wstrb_reg;
  end

  // Gated by reset so a request presented during reset never touches the array.
  assign entering_resp = reset && (state_reg != ST_RESP) && (state_next == ST_RESP);
  assign array_we      = entering_resp && c_write && !c_error;
  assign array_re      = entering_resp && !c_write && !c_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg        <= '0;
      write_reg      <= 1'b0;
      index_reg      <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      error_reg      <= 1'b0;
      load_ok_reg    <= 1'b0;
      resp_error_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        index_reg <= req_addr[ADDR_WIDTH+1:2];
        wdata_reg <= req_wdata;
        wstrb_reg <= req_wstrb;
        error_reg <= req_error;
      end
      if (entering_resp) begin
        load_ok_reg    <= !c_write && !c_error;
        resp_error_reg <= c_error;
      end
    end
  end

  mem_word_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .re    (array_re),
    .wstrb (c_wstrb),
    .index (c_index),
    .wdata (c_wdata),
    .rdata (array_rdata)
  );

  // The array's read register doubles as the response data register.
  assign resp_rdata = load_ok_reg ? array_rdata : 32'd0;
  assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives a two-wait-state and a zero-wait-state responder with the same
// request stream and compares both against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv2, rv0, rr2, rr0;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rq2, rq0, vld2, vld0, err2, err0;
  logic [31:0] rd2, rd0;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_model [int];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rq2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(vld2), .resp_ready(rr2),
    .resp_rdata(rd2), .resp_error(err2)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rq0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(vld0), .resp_ready(rr0),
    .resp_rdata(rd0), .resp_error(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on both responders; hold = cycles resp_ready stays low
  // after resp_valid; poke = try a stray store on the 2-wait DUT while it waits.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int hold, input bit poke,
                     output logic [31:0] got);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          idx, e;
    bit          seen[2], done[2], hs[2];
    int          held[2];
    logic [31:0] cap_rd[2];
    logic        cap_err[2];
    logic        v, rq, er;
    logic [31:0] rd;
    string       pfx;
    bit          poke_on;

    exp_err = ((addr >> 12) != 0) ||
              (wr && !(strb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111}));
    idx = int'(addr[11:2]);
    exp_rd = 32'd0;
    if (!exp_err) begin
      if (wr) begin
        if (!mem_model.exists(idx)) mem_model[idx] = 32'd0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem_model[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        exp_rd = mem_model[idx];
      end
    end

    @(negedge clk);
    chk("pre_ready_w2", rq2, 1);
    chk("pre_ready_w0", rq0, 1);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rv2 = 1'b1; rv0 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0; rv0 = 1'b0;
    e = 1;
    poke_on = 1'b0;
    for (int d = 0; d < 2; d++) begin
      seen[d] = 0; done[d] = 0; hs[d] = 0; held[d] = 0;
      cap_rd[d] = 32'd0; cap_err[d] = 1'b0;
    end
    while (!(done[0] && done[1]) && e < 40) begin
      if (poke_on) begin rv2 = 1'b0; poke_on = 1'b0; end
      for (int d = 0; d < 2; d++) begin
        v   = (d == 0) ? vld2 : vld0;
        rq  = (d == 0) ? rq2  : rq0;
        er  = (d == 0) ? err2 : err0;
        rd  = (d == 0) ? rd2  : rd0;
        pfx = (d == 0) ? "w2" : "w0";
        if (!done[d]) begin
          if (hs[d]) begin
            chk({pfx, "_idle_ready"}, rq, 1);
            chk({pfx, "_idle_valid"}, v, 0);
            done[d] = 1;
            if (d == 0) rr2 = 1'b0; else rr0 = 1'b0;
          end else if (v) begin
            if (!seen[d]) begin
              seen[d] = 1; cap_rd[d] = rd; cap_err[d] = er;
              chk({pfx, "_latency"}, e, (d == 0) ? 3 : 1);
              chk({pfx, "_rdata"}, rd, exp_rd);
              chk({pfx, "_error"}, er, exp_err);
            end else begin
              chk({pfx, "_hold_rdata"}, rd, cap_rd[d]);
              chk({pfx, "_hold_error"}, er, cap_err[d]);
            end
            chk({pfx, "_busy_ready"}, rq, 0);
            if (held[d] == hold) begin
              if (d == 0) rr2 = 1'b1; else rr0 = 1'b1;
              hs[d] = 1;
            end else begin
              held[d]++;
              if (poke && d == 0 && held[d] == 1) begin
                req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
                req_wstrb = 4'hF; rv2 = 1'b1; poke_on = 1'b1;
              end
            end
          end
        end
      end
      if (!(done[0] && done[1])) begin
        @(posedge clk); #1;
        e++;
      end
    end
    chk("txn_complete", {30'd0, done[0], done[1]}, 32'd3);
    rv2 = 1'b0; rr2 = 1'b0; rr0 = 1'b0;
    got = cap_rd[0];
  endtask

  initial begin
    logic [31:0] got, a;
    logic [3:0]  s;
    bit          wr;
    int          sel, hold, idx;

    reset = 1'b0; rv2 = 1'b1; rv0 = 1'b1; rr2 = 1'b0; rr0 = 1'b0;
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_w2", rq2, 1);
    chk("rst_ready_w0", rq0, 1);
    chk("rst_valid_w2", vld2, 0);
    chk("rst_valid_w0", vld0, 0);
    chk("rst_rdata_w2", rd2, 0);
    chk("rst_rdata_w0", rd0, 0);
    chk("rst_error_w2", err2, 0);
    chk("rst_error_w0", err0, 0);
    @(negedge clk);
    rv2 = 1'b0; rv0 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid_w2", vld2, 0);
    chk("post_rst_valid_w0", vld0, 0);

    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? 1023 : i;
      txn(1'b1, 32'(idx * 4), $urandom, 4'hF, 0, 1'b0, got);
    end

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0, got);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("ld_word", got, 32'hDEAD_BEEF);
    txn(1'b1, 32'h10, 32'h00AA_0000, 4'b0100, 1, 1'b0, got);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("ld_byte2", got, 32'hDEAA_BEEF);
    txn(1'b1, 32'h12, 32'h0000_CAFE, 4'b0011, 0, 1'b0, got);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("ld_half0", got, 32'hDEAA_CAFE);

    txn(1'b0, 32'h1000, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("err_range_rdata", got, 32'h0);
    txn(1'b1, 32'h10, 32'h1234_5678, 4'b0101, 0, 1'b0, got);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("err_strobe_nowrite", got, 32'hDEAA_CAFE);

    txn(1'b0, 32'h10, 32'h0, 4'b0000, 5, 1'b1, got);
    chk("bp_rdata", got, 32'hDEAA_CAFE);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("bp_no_stray_write", got, 32'hDEAA_CAFE);

    txn(1'b1, 32'h20, 32'h1111_1111, 4'hF, 0, 1'b0, got);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222; req_wstrb = 4'hF;
    rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0;
    chk("abort_in_wait", vld2, 0);
    chk("abort_busy", rq2, 0);
    reset = 1'b0;
    #1;
    chk("abort_async_ready", rq2, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 0, 1'b0, got);
    chk("abort_no_write", got, 32'h1111_1111);

    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      s    = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      if (sel == 0) a = $urandom | 32'h0000_1000;
      else begin
        idx = (sel == 1) ? 1023 : $urandom_range(0, 15);
        a = 32'(idx * 4) | 32'($urandom_range(0, 3));
      end
      txn(wr, a, $urandom, s, hold, 1'b0, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
